// File: rtl/lsu_dmem_bridge_pkg.sv
// Shared types and constants for the LSU-to-data-bus bridge: bus size codes,
// bridge FSM states and the kseg0/kseg1 physical-address mask.
package lsu_dmem_bridge_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LD_WAIT = 2'd1,
        ST_LD_RESP = 2'd2
    } bridge_state_e;

    // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) alias physical memory from address 0.
    function automatic logic [31:0] map_kseg(input logic enable, input logic [31:0] addr);
        map_kseg = (enable && addr[31:30] == 2'b10) ? (addr & KSEG_MASK) : addr;
    endfunction

endpackage

// File: rtl/lsu_dmem_bridge_store_lane_encoder.sv
// Turns a store byte-enable pattern into a bus size code and replicates the
// right-aligned store data across every lane the size could select.
module lsu_dmem_bridge_store_lane_encoder
    import lsu_dmem_bridge_pkg::*;
(
    input  logic [3:0]  strobe_i,
    input  logic [31:0] wdata_i,
    output logic [1:0]  size_o,
    output logic [31:0] wdata_o
);

    // Irregular strobe patterns fall through as word-sized with data untouched.
    always_comb begin
        size_o  = SZ_WORD;
        wdata_o = wdata_i;
        case (strobe_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                size_o  = SZ_BYTE;
                wdata_o = {4{wdata_i[7:0]}};
            end
            4'b0011, 4'b1100: begin
                size_o  = SZ_HALF;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                size_o  = SZ_WORD;
                wdata_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_dmem_bridge.sv
// Bridge from the LSU valid/ready data port to the split addr_ok/data_ok bus.
// Loads block until their data returns; store acks are absorbed by a counter.
module lsu_dmem_bridge
    import lsu_dmem_bridge_pkg::*;
#(
    parameter int MAX_WR_OUT = 2,
    parameter bit MAP_KSEG   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_strobe,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [1:0]  dbg_state_o,
    output logic [2:0]  dbg_wr_cnt_o
);

    localparam logic [2:0] MAX_WR = 3'(MAX_WR_OUT);

    bridge_state_e state_q, state_d;
    logic [2:0]    wr_cnt_q, wr_cnt_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_data_q, resp_data_d;

    logic          can_issue;
    logic          store_acc;
    logic          wr_ack;
    logic [1:0]    enc_size;
    logic [31:0]   enc_wdata;

    lsu_dmem_bridge_store_lane_encoder u_enc (
        .strobe_i (req_strobe),
        .wdata_i  (req_wdata),
        .size_o   (enc_size),
        .wdata_o  (enc_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= 3'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Acks in IDLE with nothing outstanding are stray and dropped.
    assign store_acc = req_ready && req_wen;
    assign wr_ack    = data_data_ok && (state_q == ST_IDLE) && (wr_cnt_q != 3'd0);

    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        wr_cnt_d     = wr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_ready && !req_wen) begin
                    state_d = ST_LD_WAIT;
                end
            end
            ST_LD_WAIT: begin
                if (data_data_ok) begin
                    resp_data_d  = data_rdata;
                    resp_valid_d = 1'b1;
                    state_d      = ST_LD_RESP;
                end
            end
            ST_LD_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (store_acc && !wr_ack) begin
            wr_cnt_d = wr_cnt_q + 3'd1;
        end else if (!store_acc && wr_ack) begin
            wr_cnt_d = wr_cnt_q - 3'd1;
        end
    end

    // A load waits for every store ack so the next data_ok is unambiguously its own.
    always_comb begin
        can_issue = 1'b0;
        if (state_q == ST_IDLE && req_valid) begin
            can_issue = req_wen ? (wr_cnt_q < MAX_WR) : (wr_cnt_q == 3'd0);
        end
        data_req   = can_issue;
        req_ready  = can_issue && data_addr_ok;
        data_wr    = req_wen;
        data_addr  = map_kseg(MAP_KSEG, req_addr);
        data_size  = req_wen ? enc_size : SZ_WORD;
        data_wstrb = req_wen ? req_strobe : 4'b0000;
        data_wdata = req_wen ? enc_wdata : 32'd0;
    end

    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign dbg_state_o  = state_q;
    assign dbg_wr_cnt_o = wr_cnt_q;

endmodule
